// File: rtl/dmem_uart_bridge.sv
// Data-side memory bridge for the M stage: word RAM plus MMIO UART TX and cycle counter.
// Load data is combinational so the core can sample it in the same cycle.
module dmem_uart_bridge #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo [FIFO_DEPTH];

  logic [FW-1:0] wp;
  logic [FW-1:0] rp;
  logic [FW:0]   count;
  logic          ovf;
  logic [31:0]   cyc;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bitn;
  logic [7:0]    sh;

  logic sel_ram;
  logic sel_tx;
  logic sel_st;
  logic sel_cy;
  logic full;
  logic empty;
  logic busy;
  logic push;
  logic pop;
  logic tick;
  logic [31:0] status;
  logic unused_adr;

  assign unused_adr = ^adr[1:0];

  assign sel_ram = (adr[31:AW+2] == '0);
  assign sel_tx  = (adr[31:2] == 30'h3FFF_C000);
  assign sel_st  = (adr[31:2] == 30'h3FFF_C001);
  assign sel_cy  = (adr[31:2] == 30'h3FFF_C002);

  assign full  = (count == (FW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign push  = we & sel_tx & ~full;
  assign pop   = (state == IDLE) & ~empty;
  assign tick  = (timer == TW'(CLK_DIV - 1));

  assign status = {24'h0, 4'(count), ovf, empty, full, busy};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ram: rdata = ram[adr[AW+1:2]];
      sel_st:  rdata = status;
      sel_cy:  rdata = cyc;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we && sel_ram)
      ram[adr[AW+1:2]] <= wdata;
    if (push)
      fifo[wp] <= wdata[7:0];
  end

  // Fullness is judged before the edge, so a same-edge pop never admits a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      cyc   <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (we && sel_st)
        ovf <= 1'b0;
      else if (we && sel_tx && full)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= 1'b1;
      timer <= '0;
      bitn  <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (!empty) begin
            sh    <= fifo[rp];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            timer <= '0;
            tx    <= sh[0];
            bitn  <= '0;
            state <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            timer <= '0;
            // sh[0] is the bit on the wire; sh[1] is next
            sh    <= sh >> 1;
            if (bitn == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx   <= sh[1];
              bitn <= bitn + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          if (tick) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
